// File: rtl/boot_loader_pkg.sv
// Shared definitions for the stream boot loader.
// Contents: loader state encoding, RAM access-size code and frame field sizes.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      WRITE = 3'd2,
      CSUM  = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   // RAM data_size code for a full 32-bit access
   localparam logic [1:0] DATA_SIZE_WORD = 2'b11;

   // Frame field sizes in bytes; header, payload words and checksum are all one word
   localparam int WORD_BYTES = 4;
   localparam int HDR_BYTES  = WORD_BYTES;
   localparam int CSUM_BYTES = WORD_BYTES;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler shared by header, payload and checksum.
// Ports:
//   clk        - system clock
//   clear      - synchronous clear of the byte counter and partial word
//   push       - a byte is accepted this cycle
//   data_byte  - the byte being accepted
//   word       - assembled word including the byte currently being pushed
//   word_valid - one-cycle pulse when the 4th byte of a word is pushed
module word_assembler
   import boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  data_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

   logic [1:0]  count_r;
   logic [23:0] shift_r;

   // Byte counter and the three earlier bytes of the word in flight
   always_ff @(posedge clk) begin
      if (clear) begin
         count_r <= 2'd0;
         shift_r <= 24'd0;
      end else if (push) begin
         count_r <= count_r + 2'd1;
         shift_r <= {data_byte, shift_r[23:8]};
      end else begin
         count_r <= count_r;
         shift_r <= shift_r;
      end
   end

   // The word is offered combinationally on the 4th byte so the consumer can
   // register it on the very edge that accepts that byte.
   assign word       = {data_byte, shift_r};
   assign word_valid = push && (count_r == LAST_BYTE);

endmodule

// File: rtl/stream_boot_loader.sv
// Boot-time loader: consumes a framed byte stream (word count, little-endian
// payload words, additive checksum), writes the payload into RAM and releases
// the CPU reset only when the checksum matches.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   in_valid/in_data/in_ready - byte stream handshake
//   address/data_input       - RAM write address and data
//   cs/we/oe/data_size       - RAM controls (oe always 0, word-sized access)
//   mem_done                 - RAM write completion
//   loading                  - RAM mux select, 1 while the loader owns RAM
//   cpu_rst                  - core reset, held until a verified image
//   finished/error           - load ended / load failed
module stream_boot_loader #(
   parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] address,
   output logic [31:0] data_input,
   output logic        cs,
   output logic        we,
   output logic        oe,
   output logic [1:0]  data_size,
   input  logic        mem_done,
   output logic        loading,
   output logic        cpu_rst,
   output logic        finished,
   output logic        error
);
   import boot_loader_pkg::*;

   localparam int IDX_W = $clog2(MAX_WORDS + 1);

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic [IDX_W-1:0]   n_r, n_s;
   logic [31:0]        sum_r, sum_s;
   logic [31:0]        data_s;
   logic [31:0]        word_s;
   logic               word_valid_s;
   logic               push_s;

   // in_ready is only high in collect states, so a push always belongs to one
   assign push_s = in_valid && in_ready;

   word_assembler u_asm (
      .clk        (clk),
      .clear      (rst),
      .push       (push_s),
      .data_byte  (in_data),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   assign oe        = 1'b0;
   assign data_size = DATA_SIZE_WORD;

   // Next-state and next datapath values
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      n_s     = n_r;
      sum_s   = sum_r;
      data_s  = data_input;
      case (state_r)
         HDR: begin
            if (word_valid_s) begin
               if (word_s == 32'd0) begin
                  n_s     = {IDX_W{1'b0}};
                  state_s = CSUM;
               end else if (word_s > 32'(MAX_WORDS)) begin
                  state_s = ERR;
               end else begin
                  n_s     = word_s[IDX_W-1:0];
                  state_s = DATA;
               end
            end else begin
               state_s = HDR;
            end
         end
         DATA: begin
            if (word_valid_s) begin
               data_s  = word_s;
               state_s = WRITE;
            end else begin
               state_s = DATA;
            end
         end
         WRITE: begin
            if (mem_done) begin
               sum_s = sum_r + data_input;
               idx_s = idx_r + IDX_W'(1);
               if (idx_s == n_r) begin
                  state_s = CSUM;
               end else begin
                  state_s = DATA;
               end
            end else begin
               state_s = WRITE;
            end
         end
         CSUM: begin
            if (word_valid_s) begin
               if (word_s == sum_r) begin
                  state_s = DONE;
               end else begin
                  state_s = ERR;
               end
            end else begin
               state_s = CSUM;
            end
         end
         DONE:    state_s = DONE;
         ERR:     state_s = ERR;
         default: state_s = ERR;
      endcase
   end

   // State, counters and registered outputs; outputs follow the next state so
   // they change on the same edge as the transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= HDR;
         idx_r      <= {IDX_W{1'b0}};
         n_r        <= {IDX_W{1'b0}};
         sum_r      <= 32'd0;
         in_ready   <= 1'b0;
         cs         <= 1'b0;
         we         <= 1'b0;
         address    <= LOAD_BASE;
         data_input <= 32'd0;
         loading    <= 1'b1;
         cpu_rst    <= 1'b1;
         finished   <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         n_r        <= n_s;
         sum_r      <= sum_s;
         in_ready   <= (state_s == HDR) || (state_s == DATA) || (state_s == CSUM);
         cs         <= (state_s == WRITE);
         we         <= (state_s == WRITE);
         address    <= LOAD_BASE + (32'(idx_s) << 2'd2);
         data_input <= data_s;
         loading    <= !((state_s == DONE) || (state_s == ERR));
         cpu_rst    <= (state_s != DONE);
         finished   <= (state_s == DONE) || (state_s == ERR);
         error      <= (state_s == ERR);
      end
   end

endmodule

// File: doc/stream_boot_loader.md
# stream_boot_loader

Boot-time loader upstream of `basic_ram`. It consumes a framed byte stream (length header, little-endian payload words, additive checksum) and writes each assembled 32-bit word into RAM over the RAM's cs/we/oe/mem_done handshake. It drives the loader-versus-core select and holds the ARMv4 core in reset until the image is verified, releasing the core only on success.

## Interface

Parameters:
- `LOAD_BASE`, 32'h0000_0000, byte address of the first payload word; must be word-aligned.
- `MAX_WORDS`, 4096, largest accepted payload word count.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: stream byte valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready` at a rising edge.
- `address` out 32: RAM byte address.
- `data_input` out 32: RAM write data.
- `cs`, `we`, `oe` out 1 each: RAM controls. `oe` is always 0.
- `data_size` out 2: constant 2'b11 (word).
- `mem_done` in 1: RAM write complete.
- `loading` out 1: RAM mux select; 1 while the loader owns RAM.
- `cpu_rst` out 1: reset to the ARMv4 core.
- `finished` out 1: load ended, on success or on error.
- `error` out 1: load failed.

## Operation

Frame format:
- 4 bytes: word count N, little-endian.
- N×4 bytes: payload words, little-endian.
- 4 bytes: checksum, equal to the sum mod 2^32 of all payload words.

States:
- **HDR**: `in_ready`=1; collect 4 bytes into N.
  - N==0 → CSUM.
  - N>MAX_WORDS → ERR.
  - Otherwise → DATA.
- **DATA**: `in_ready`=1; collect 4 bytes into a word. When the 4th byte is accepted → WRITE.
- **WRITE**: `in_ready`=0; `cs`=1, `we`=1, `address`=LOAD_BASE+4·idx, `data_input`=word. Held until `mem_done`=1 is sampled. Then:
  - add word to running sum (32-bit, wraps);
  - idx += 1;
  - idx==N → CSUM, else → DATA.
- **CSUM**: `in_ready`=1; collect 4 bytes.
  - Match → DONE.
  - Mismatch → ERR.
- **DONE**: terminal. `finished`=1, `loading`=0, `cpu_rst`=0, `in_ready`=0.
- **ERR**: terminal. `finished`=1, `error`=1, `loading`=0, `cpu_rst`=1, `in_ready`=0. Further input bytes are not accepted.

Additional rules:
- The byte index within a word and `idx` are counters; `idx` is 13 bits for the default `MAX_WORDS`.
- `mem_done` is ignored outside WRITE.

## Timing

- Reset values: `in_ready`=0, `cs`=`we`=`oe`=0, `address`=LOAD_BASE, `data_input`=0, `data_size`=2'b11, `loading`=1, `cpu_rst`=1, `finished`=0, `error`=0, state=HDR, idx=0, sum=0.
- `in_ready` is registered and is 1 starting the first cycle after `rst` deasserts.
- All RAM outputs are registered:
  - 4th byte accepted at edge k → `cs`/`we` high from edge k.
  - `mem_done` sampled high at edge m → `cs`/`we` low and `in_ready` high from edge m.
  - At least one cycle with `cs` low between consecutive writes.
- Best case per word: 4 byte cycles + 1 + RAM latency.
- `in_valid` bubbles stall the current collect state with no side effects.
- `loading`, `cpu_rst` and `finished` change on the same edge as the final state transition.
- Reset mid-operation (including during WRITE with `cs` high): next edge returns every output to its reset value. The partial word is discarded; the RAM write is abandoned.

## Structure

- Package `boot_loader_pkg`:
  - state enum (HDR, DATA, WRITE, CSUM, DONE, ERR);
  - `DATA_SIZE_WORD`=2'b11;
  - frame header/checksum byte counts.
- Sub-module `word_assembler`: shifts 4 bytes into a little-endian word, with byte counter, `clear`, and a `word_valid` pulse. It is reused for header, payload and checksum.

## Test plan

- N=2, words 32'h11223344 and 32'hAABBCCDD, checksum 32'hBBDE0021:
  - RAM[0] and RAM[4] hold the words;
  - `finished`=1, `error`=0, `cpu_rst`=0, `loading`=0.
- N=0, checksum 0:
  - no `cs` pulse;
  - DONE with `cpu_rst`=0.
- N=1, word 32'h1, checksum 32'h2:
  - RAM[0]=1 is written;
  - `error`=1, `cpu_rst` stays 1, `in_ready`=0.
- N=MAX_WORDS+1:
  - ERR immediately after the 4th header byte;
  - no `cs` asserted.
- RAM with 5-cycle `mem_done` latency, plus random `in_valid` gaps:
  - `cs` held exactly until `mem_done`;
  - addresses increment by 4;
  - `in_ready`=0 throughout WRITE.
- `rst` pulsed while `cs`=1 on word 3, then a full N=2 frame is sent:
  - outputs are at reset values the cycle after `rst`;
  - the second load completes correctly from `LOAD_BASE`.
